// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer encodings and memory front-end state type
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'b000,
        HSIZE_HALF   = 3'b001,
        HSIZE_WORD   = 3'b010,
        HSIZE_DWORD  = 3'b011,
        HSIZE_4WORD  = 3'b100,
        HSIZE_8WORD  = 3'b101,
        HSIZE_16WORD = 3'b110,
        HSIZE_32WORD = 3'b111
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_ERR1      = 3'd4,
        ST_ERR2      = 3'd5
    } ahb_mem_state_t;

    // True when the requested transfer is wider than one memory word.
    function automatic logic size_exceeds(input logic [2:0] hsize, input int unsigned data_width);
        return (32'd1 << hsize) > (data_width / 32'd8);
    endfunction

endpackage

// File: rtl/ahb_mem_ctrl.sv
// rtl/ahb_mem_ctrl.sv - AHB-Lite slave driving a single-port memory; define AHB_MEM_RDWAIT_EN for registered 2-cycle reads
module ahb_mem_ctrl
    import ahb_pkg::*;
#(
    parameter int SLAVE_ADDRWIDTH = 8,
    parameter int SLAVE_DATAWIDTH = 8
) (
    input  logic                       clk,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [31:0]                HADDR,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [1:0]                 HTRANS,
    input  logic                       HREADY,
    input  logic [31:0]                HWDATA,
    output logic [31:0]                HRDATA,
    output logic                       HREADYOUT,
    output logic                       HRESP,
    output logic                       mem_rdEn,
    output logic                       mem_wrEn,
    output logic [SLAVE_ADDRWIDTH-1:0] mem_Addr,
    output logic [SLAVE_DATAWIDTH-1:0] mem_Datai,
    input  logic [SLAVE_DATAWIDTH-1:0] mem_Datao
);

    ahb_mem_state_t               state_q, state_d;
    ahb_mem_state_t               target;
    logic [SLAVE_ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [SLAVE_ADDRWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                         hreadyout_q, hreadyout_d;
    logic                         hresp_q, hresp_d;
    logic                         rd_en_q, rd_en_d;
    logic                         wr_en_q, wr_en_d;
    logic                         can_accept;
    logic                         accept;
    logic                         unused_ok;
`ifdef AHB_MEM_RDWAIT_EN
    logic [SLAVE_DATAWIDTH-1:0]   rdata_q, rdata_d;
`endif

    assign unused_ok = ^{HADDR, HWDATA};

    always_comb begin
        // ERR1 and the first READ cycle hold HREADYOUT low, so nothing new can start there.
        can_accept = (state_q != ST_ERR1);
`ifdef AHB_MEM_RDWAIT_EN
        can_accept = can_accept && (state_q != ST_READ);
`endif
        accept = can_accept && HSEL && HREADY &&
                 (htrans_t'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ});

        if (size_exceeds(HSIZE, SLAVE_DATAWIDTH)) begin
            target = ST_ERR1;
        end else if (HWRITE) begin
            target = ST_WRITE;
        end else begin
            target = ST_READ;
        end

        addr_d = accept ? HADDR[SLAVE_ADDRWIDTH-1:0] : addr_q;

        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_MEM_RDWAIT_EN
            ST_READ: state_d = ST_READ_WAIT;
`endif
            default: state_d = accept ? target : ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        hreadyout_d = (state_d != ST_ERR1);
`ifdef AHB_MEM_RDWAIT_EN
        hreadyout_d = hreadyout_d && (state_d != ST_READ);
        rdata_d     = (state_q == ST_READ) ? mem_Datao : rdata_q;
`endif
        hresp_d    = (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
        wr_en_d    = (state_d == ST_WRITE);
        rd_en_d    = (state_d == ST_READ);
        mem_addr_d = (state_d inside {ST_WRITE, ST_READ, ST_READ_WAIT}) ? addr_d : '0;
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
`ifdef AHB_MEM_RDWAIT_EN
            rdata_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
`ifdef AHB_MEM_RDWAIT_EN
            rdata_q     <= rdata_d;
`endif
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign mem_rdEn  = rd_en_q;
    assign mem_wrEn  = wr_en_q;
    assign mem_Addr  = mem_addr_q;
    assign mem_Datai = HWDATA[SLAVE_DATAWIDTH-1:0];

`ifdef AHB_MEM_RDWAIT_EN
    assign HRDATA = (state_q == ST_READ_WAIT) ? 32'(rdata_q) : 32'd0;
`else
    assign HRDATA = rd_en_q ? 32'(mem_Datao) : 32'd0;
`endif

endmodule

// File: tb/tb_ahb_mem_ctrl.sv
// tb/tb_ahb_mem_ctrl.sv - randomized bench for ahb_mem_ctrl against a transfer-level bus/memory model
module tb_ahb_mem_ctrl;
    import ahb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        logic          sel;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
    } xfer_t;

    logic          clk = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          mem_rdEn;
    logic          mem_wrEn;
    logic [AW-1:0] mem_Addr;
    logic [DW-1:0] mem_Datai;
    logic [DW-1:0] mem_Datao;

    always #5 clk = ~clk;

    ahb_mem_ctrl #(.SLAVE_ADDRWIDTH(AW), .SLAVE_DATAWIDTH(DW)) dut (
        .clk       (clk),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .mem_rdEn  (mem_rdEn),
        .mem_wrEn  (mem_wrEn),
        .mem_Addr  (mem_Addr),
        .mem_Datai (mem_Datai),
        .mem_Datao (mem_Datao)
    );

    assign HREADY = HREADYOUT;

    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) if (mem_wrEn) mem[mem_Addr] <= mem_Datai;
    assign mem_Datao = mem[mem_Addr];

    logic [DW-1:0] ref_mem [256];
    xfer_t         q[$];
    xfer_t         cur;
    bit            have_cur;
    bit            p_valid, p_write, p_err;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    int            p_cyc;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic sel, input logic [1:0] trans, input logic write,
                        input logic [2:0] size, input logic [31:0] addr, input logic [DW-1:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write;
        x.size = size; x.addr = addr; x.wdata = wdata;
        q.push_back(x);
    endtask

    // One bus clock: present an address phase, check the data phase in flight, advance the model.
    task automatic cycle();
        logic [31:0]   wd;
        logic          e_rdy, e_resp, e_wr, e_rd, acc;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_rdata;
        if (!have_cur && q.size() > 0) begin
            cur = q.pop_front();
            have_cur = 1'b1;
        end
        if (have_cur) begin
            HSEL = cur.sel; HTRANS = cur.trans; HWRITE = cur.write;
            HSIZE = cur.size; HADDR = cur.addr;
        end else begin
            HSEL = 1'($urandom); HTRANS = 2'b00; HWRITE = 1'($urandom);
            HSIZE = 3'd0; HADDR = $urandom;
        end
        wd = $urandom;
        if (p_valid && p_write && !p_err) wd[DW-1:0] = p_wdata;
        HWDATA = wd;

        e_rdy = 1'b1; e_resp = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_rdata = 32'd0;
        if (p_valid) begin
            if (p_err) begin
                e_resp = 1'b1;
                e_rdy  = (p_cyc != 0);
            end else if (p_write) begin
                e_wr = 1'b1; e_addr = p_addr;
            end else begin
                e_addr = p_addr;
`ifdef AHB_MEM_RDWAIT_EN
                if (p_cyc == 0) begin
                    e_rd = 1'b1; e_rdy = 1'b0;
                end else begin
                    e_rdata = 32'(ref_mem[p_addr]);
                end
`else
                e_rd = 1'b1;
                e_rdata = 32'(ref_mem[p_addr]);
`endif
            end
        end

        @(negedge clk);
        check("hreadyout", 32'(HREADYOUT), 32'(e_rdy));
        check("hresp", 32'(HRESP), 32'(e_resp));
        check("mem_wren", 32'(mem_wrEn), 32'(e_wr));
        check("mem_rden", 32'(mem_rdEn), 32'(e_rd));
        check("mem_addr", 32'(mem_Addr), 32'(e_addr));
        check("hrdata", HRDATA, e_rdata);
        if (e_wr) check("mem_datai", 32'(mem_Datai), 32'(p_wdata));

        @(posedge clk);
        acc = have_cur && cur.sel && cur.trans[1] && e_rdy;
        if (e_rdy) begin
            if (p_valid && p_write && !p_err) ref_mem[p_addr] = p_wdata;
            if (acc) begin
                p_valid = 1'b1;
                p_write = cur.write;
                p_err   = ((32'd1 << cur.size) > (DW / 8));
                p_addr  = cur.addr[AW-1:0];
                p_wdata = cur.wdata;
            end else begin
                p_valid = 1'b0;
            end
            p_cyc = 0;
            have_cur = 1'b0;
        end else begin
            p_cyc++;
        end
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((q.size() > 0 || have_cur || p_valid) && budget > 0) begin
            cycle();
            budget--;
        end
        check("drain_budget", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        logic [31:0] a32;
        logic [2:0]  sz;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        have_cur = 1'b0; p_valid = 1'b0; p_write = 1'b0; p_err = 1'b0;
        p_addr = '0; p_wdata = '0; p_cyc = 0;

        HRESETn = 1'b0; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
        HSIZE = HSIZE_BYTE; HADDR = 32'h10; HWDATA = 32'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
            check("rst_hresp", 32'(HRESP), 32'd0);
            check("rst_hrdata", HRDATA, 32'd0);
            check("rst_rden", 32'(mem_rdEn), 32'd0);
            check("rst_wren", 32'(mem_wrEn), 32'd0);
            check("rst_addr", 32'(mem_Addr), 32'd0);
        end
        @(posedge clk); #1;
        HRESETn = 1'b1;

        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h10, 8'hA5);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h10, 8'h00);
        drain();

        for (int i = 0; i < 4; i++)
            push(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1, HSIZE_BYTE, 32'(i), 8'(i + 1));
        for (int i = 3; i >= 0; i--)
            push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'(i), 8'h00);
        drain();

        push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h08, 8'h00);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h02, 8'h00);
        push(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h02, 8'hEE);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h02, 8'h00);
        drain();

        push(1, HTRANS_BUSY, 1, HSIZE_BYTE, 32'h07, 8'h66);
        push(1, HTRANS_IDLE, 1, HSIZE_BYTE, 32'h07, 8'h66);
        push(1, HTRANS_BUSY, 0, HSIZE_BYTE, 32'h07, 8'h00);
        drain();

        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h40, 8'h3C);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h40, 8'h00);
        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h40, 8'h99);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h40, 8'h00);
        drain();

        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'hFFFF_FF20, 8'h5A);
        drain();
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h0000_0020, 8'h00);
        drain();

        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h05, 8'h11);
        push(0, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h05, 8'h00);
        push(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h05, 8'h00);
        drain();

        // Reset asserted in the middle of a write data phase must suppress the write.
        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h33, 8'h77);
        cycle();
        check("midrst_wren_before", 32'(mem_wrEn), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("midrst_wren", 32'(mem_wrEn), 32'd0);
        check("midrst_addr", 32'(mem_Addr), 32'd0);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        @(posedge clk); #1;
        check("midrst_mem", 32'(mem[8'h33]), 32'(ref_mem[8'h33]));
        HRESETn = 1'b1;
        p_valid = 1'b0; p_cyc = 0;

        repeat (400) begin
            a32 = $urandom;
            a32[7:4] = 4'h0;
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
            push(logic'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                 sz, a32, 8'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
